mult_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit directly downstream of register_file; consumes Da/Db

---
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style multiply/divide unit. It takes one shift-add (multiply) or one
// restoring-subtract (divide) step per clock and leaves the 2*WIDTH-bit result in HI/LO.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Da,
  input  logic [WIDTH-1:0] Db,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 is_div_q, is_div_d;
  logic                 quo_neg_q, quo_neg_d;  // negate product / quotient at fix-up
  logic                 rem_neg_q, rem_neg_d;  // negate remainder at fix-up
  logic                 dz_q, dz_d;            // divisor was zero
  logic [WIDTH-1:0]     opnd_q, opnd_d;        // |A| for multiply, |B| for divide
  logic [2*WIDTH-1:0]   acc_q, acc_d;          // mul: {partial, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, mul_hi;
  logic [WIDTH:0]       rem_sh, trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     rem, quo;

  // Operand magnitudes, single step datapaths and result sign fix-up.
  always_comb begin
    a_mag = (op[0] && Da[WIDTH-1]) ? -Da : Da;
    b_mag = (op[0] && Db[WIDTH-1]) ? -Db : Db;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_hi   = acc_q[0] ? mul_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    mul_next = {mul_hi, acc_q[WIDTH-1:1]};

    // Bit WIDTH of rem_sh can only be set when the trial subtract succeeds, so dropping it
    // on the restore path loses nothing.
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, opnd_q};
    div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod = quo_neg_q ? -acc_q : acc_q;
    rem  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    quo  = quo_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  // Next-state logic: IDLE accepts, RUN iterates WIDTH times, FIX publishes the result.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    is_div_d   = is_div_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    dz_d       = dz_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          count_d    = '0;
          is_div_d   = op[1];
          opnd_d     = op[1] ? b_mag : a_mag;
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          quo_neg_d  = op[0] & (Da[WIDTH-1] ^ Db[WIDTH-1]);
          rem_neg_d  = op[0] & Da[WIDTH-1];
          dz_d       = op[1] & (Db == '0);
          div_zero_d = 1'b0;
        end
      end
      StRun: begin
        acc_d   = is_div_q ? div_next : mul_next;
        count_d = count_q + 1'b1;
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d    = StIdle;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          // With a zero divisor the remainder equals |Da|; undoing the dividend sign
          // restores the original Da bits.
          hi_d = rem;
          lo_d = dz_q ? {WIDTH{1'b1}} : quo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      is_div_q   <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      is_div_q   <= is_div_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      dz_q       <= dz_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit plus hand-written multi-cycle sequences.
module tb_mult_div_unit;

  localparam int unsigned W   = 32;
  localparam int          Lat = W + 1;

  logic          clk, rst_n, start;
  logic [1:0]    op;
  logic [W-1:0]  Da, Db;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .Da       (Da),
    .Db       (Db),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts falling edges until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Launch one op, scramble inputs after acceptance, return observed latency.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string name);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; Da = a; Db = b;
    @(negedge clk);
    start = 1'b0; op = ~o; Da = ~a; Db = ~b;
    check({name, " busy after accept"}, 64'(busy), 64'd1);
    check({name, " div_zero cleared on accept"}, 64'(div_zero), 64'd0);
    wait_done(lat);
    check({name, " latency"}, 64'(lat), 64'(Lat));
    check({name, " busy low at done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat, lat2, seen_done;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b00, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
    vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[11] = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[12] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[13] = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; Da = '0; Db = '0;
    #12;
    check("reset outputs {busy,done,div_zero,hi,lo}", {busy, done, div_zero, hi[28:0], lo},
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
      check($sformatf("vec%0d div_zero", i), 64'(div_zero), 64'(vecs[i].dz));
      @(negedge clk);
      check($sformatf("vec%0d done one cycle", i), 64'(done), 64'd0);
    end

    // start during busy is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; Da = 32'd5; Db = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b10; Da = 32'd9; Db = 32'd4;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ignored start latency", 64'(lat + 11), 64'(Lat));
    check("ignored start result", {hi, lo}, 64'd30);
    @(negedge clk);
    check("ignored start no restart", 64'(busy), 64'd0);

    // start held through done: back-to-back accept in the done cycle
    start = 1'b1; op = 2'b00; Da = 32'd7; Db = 32'd8;
    @(negedge clk);
    op = 2'b10; Da = 32'd100; Db = 32'd7;
    wait_done(lat);
    check("b2b first latency", 64'(lat), 64'(Lat));
    check("b2b first result", {hi, lo}, 64'd56);
    @(negedge clk);
    start = 1'b0; Da = '0; Db = '0;
    check("b2b done drops", 64'(done), 64'd0);
    check("b2b busy rises", 64'(busy), 64'd1);
    check("b2b result held", {hi, lo}, 64'd56);
    wait_done(lat2);
    check("b2b second latency", 64'(lat2), 64'(Lat));
    check("b2b second result", {hi, lo}, {32'd2, 32'd14});

    // async reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 2'b11; Da = 32'hFFFFFFF9; Db = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-op reset busy/done", {busy, done}, 64'd0);
    check("mid-op reset hi/lo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    check("no done/busy after reset release", 64'(seen_done), 64'd0);

    run_op(2'b01, 32'hFFFFFFFE, 32'h00000003, "post-reset MULT");
    check("post-reset MULT result", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
